// File: rtl/e203_exu_wbck_arb_if.sv
// Write-back request bundle between the execution units and the arbiter.
// Channel c occupies slice c of every packed field.
interface e203_exu_wbck_arb_if #(
  parameter int NCH     = 3,
  parameter int FLEN    = 32,
  parameter int RFIDX_W = 5
);
  logic [NCH-1:0]         valid;
  logic [NCH-1:0]         ready;
  logic [NCH*FLEN-1:0]    wdat;
  logic [NCH*5-1:0]       flags;
  logic [NCH*RFIDX_W-1:0] rdidx;
  logic [NCH-1:0]         rdfpu;

  // Execution units drive requests and observe grants.
  modport master (output valid, wdat, flags, rdidx, rdfpu, input ready);
  // Arbiter observes requests and drives grants.
  modport slave  (input valid, wdat, flags, rdidx, rdfpu, output ready);
endinterface

// File: rtl/e203_exu_wbck_arb.sv
// EXU write-back arbiter: grants one integer and (optionally) one FP
// write-back per cycle, registers the winners into a one-cycle output
// stage and accumulates FP exception flags into a sticky register.
module e203_exu_wbck_arb #(
  parameter int NCH     = 3,
  parameter int XLEN    = 32,
  parameter int FLEN    = 32,
  parameter int RFIDX_W = 5,
  parameter int RR_MODE = 0,
  parameter int DUAL_WB = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  e203_exu_wbck_arb_if.slave  wbck_i,
  output logic                rf_wbck_o_ena,
  output logic [XLEN-1:0]     rf_wbck_o_wdat,
  output logic [RFIDX_W-1:0]  rf_wbck_o_rdidx,
  output logic                frf_wbck_o_ena,
  output logic [FLEN-1:0]     frf_wbck_o_wdat,
  output logic [RFIDX_W-1:0]  frf_wbck_o_rdidx,
  input  logic                fflags_clr,
  output logic [4:0]          fflags_o
);

  localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

  // One-hot grant: first requester scanning from ptr (round-robin) or from 0.
  function automatic logic [NCH-1:0] arb_pick(input logic [NCH-1:0] req,
                                               input logic [PTR_W-1:0] ptr);
    logic [NCH-1:0] gnt;
    int             idx;
    gnt = '0;
    for (int k = 0; k < NCH; k++) begin
      idx = (RR_MODE != 0) ? (int'(ptr) + k) % NCH : k;
      if (gnt == '0 && req[idx]) gnt[idx] = 1'b1;
    end
    return gnt;
  endfunction

  // Pointer moves to the channel after the winner; holds without a grant.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [NCH-1:0] gnt,
                                                 input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    nxt = ptr;
    if (RR_MODE != 0) begin
      for (int c = 0; c < NCH; c++) begin
        if (gnt[c]) nxt = (c == NCH - 1) ? '0 : PTR_W'(c + 1);
      end
    end
    return nxt;
  endfunction

  logic [NCH-1:0]     req_a, req_b, gnt_a, gnt_b, acc;
  logic [PTR_W-1:0]   ptr_a_d, ptr_a_q, ptr_b_d, ptr_b_q;
  logic               rf_ena_d, rf_ena_q, frf_ena_d, frf_ena_q;
  logic [XLEN-1:0]    rf_wdat_d, rf_wdat_q;
  logic [FLEN-1:0]    frf_wdat_d, frf_wdat_q;
  logic [RFIDX_W-1:0] rf_rdidx_d, rf_rdidx_q, frf_rdidx_d, frf_rdidx_q;
  logic [4:0]         new_flags, fflags_d, fflags_q;

  // Arbitration, acceptance and next-state of the output stage and flags.
  always_comb begin
    // NOTE: every variable gets a default before any branch so the block
    // describes pure logic and never infers a latch.
    req_a       = wbck_i.valid;
    req_b       = '0;
    rf_ena_d    = 1'b0;
    rf_wdat_d   = rf_wdat_q;
    rf_rdidx_d  = rf_rdidx_q;
    frf_ena_d   = 1'b0;
    frf_wdat_d  = frf_wdat_q;
    frf_rdidx_d = frf_rdidx_q;
    new_flags   = '0;

    // Dual mode: arbiter A serves int targets, arbiter B serves FP targets.
    // Single mode: arbiter A sees everything and B stays idle.
    if (DUAL_WB != 0) begin
      req_a = wbck_i.valid & ~wbck_i.rdfpu;
      req_b = wbck_i.valid &  wbck_i.rdfpu;
    end

    gnt_a   = arb_pick(req_a, ptr_a_q);
    gnt_b   = arb_pick(req_b, ptr_b_q);
    ptr_a_d = ptr_next(gnt_a, ptr_a_q);
    ptr_b_d = ptr_next(gnt_b, ptr_b_q);

    // Grants are suppressed while reset is held.
    acc = (gnt_a | gnt_b) & {NCH{rst_n}};

    for (int c = 0; c < NCH; c++) begin
      if (acc[c]) begin
        new_flags = new_flags | wbck_i.flags[c*5 +: 5];
        if (wbck_i.rdfpu[c]) begin
          frf_ena_d   = 1'b1;
          frf_wdat_d  = wbck_i.wdat[c*FLEN +: FLEN];
          frf_rdidx_d = wbck_i.rdidx[c*RFIDX_W +: RFIDX_W];
        end else begin
          rf_ena_d    = 1'b1;
          rf_wdat_d   = wbck_i.wdat[c*FLEN +: XLEN];
          rf_rdidx_d  = wbck_i.rdidx[c*RFIDX_W +: RFIDX_W];
        end
      end
    end

    // Newly raised flags win over a concurrent clear.
    fflags_d = (fflags_clr ? 5'b0 : fflags_q) | new_flags;
  end

  assign wbck_i.ready = acc;

  // Output stage, sticky flags and arbitration pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_a_q     <= '0;
      ptr_b_q     <= '0;
      rf_ena_q    <= 1'b0;
      rf_wdat_q   <= '0;
      rf_rdidx_q  <= '0;
      frf_ena_q   <= 1'b0;
      frf_wdat_q  <= '0;
      frf_rdidx_q <= '0;
      fflags_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the values
      // from before this edge, independent of statement order.
      ptr_a_q     <= ptr_a_d;
      ptr_b_q     <= ptr_b_d;
      rf_ena_q    <= rf_ena_d;
      rf_wdat_q   <= rf_wdat_d;
      rf_rdidx_q  <= rf_rdidx_d;
      frf_ena_q   <= frf_ena_d;
      frf_wdat_q  <= frf_wdat_d;
      frf_rdidx_q <= frf_rdidx_d;
      fflags_q    <= fflags_d;
    end
  end

  assign rf_wbck_o_ena    = rf_ena_q;
  assign rf_wbck_o_wdat   = rf_wdat_q;
  assign rf_wbck_o_rdidx  = rf_rdidx_q;
  assign frf_wbck_o_ena   = frf_ena_q;
  assign frf_wbck_o_wdat  = frf_wdat_q;
  assign frf_wbck_o_rdidx = frf_rdidx_q;
  assign fflags_o         = fflags_q;

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Directed bench for the write-back arbiter. Three instances share one
// stimulus: fixed-priority dual, round-robin dual and fixed-priority single.
module tb_e203_exu_wbck_arb;

  localparam int NCH = 3;
  localparam int FL  = 32;
  localparam int RW  = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    valid, rdfpu;
  logic [NCH*FL-1:0] wdat;
  logic [NCH*5-1:0]  flags;
  logic [NCH*RW-1:0] rdidx;
  logic              fflags_clr;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  e203_exu_wbck_arb_if #(.NCH(NCH), .FLEN(FL), .RFIDX_W(RW)) if_fix ();
  e203_exu_wbck_arb_if #(.NCH(NCH), .FLEN(FL), .RFIDX_W(RW)) if_rr  ();
  e203_exu_wbck_arb_if #(.NCH(NCH), .FLEN(FL), .RFIDX_W(RW)) if_sgl ();

  assign if_fix.valid = valid;  assign if_fix.rdfpu = rdfpu;
  assign if_fix.wdat  = wdat;   assign if_fix.flags = flags;
  assign if_fix.rdidx = rdidx;
  assign if_rr.valid  = valid;  assign if_rr.rdfpu  = rdfpu;
  assign if_rr.wdat   = wdat;   assign if_rr.flags  = flags;
  assign if_rr.rdidx  = rdidx;
  assign if_sgl.valid = valid;  assign if_sgl.rdfpu = rdfpu;
  assign if_sgl.wdat  = wdat;   assign if_sgl.flags = flags;
  assign if_sgl.rdidx = rdidx;

  logic          fx_rf_ena, fx_frf_ena, rr_rf_ena, rr_frf_ena, sg_rf_ena, sg_frf_ena;
  logic [31:0]   fx_rf_wdat, fx_frf_wdat, rr_rf_wdat, rr_frf_wdat, sg_rf_wdat, sg_frf_wdat;
  logic [RW-1:0] fx_rf_idx, fx_frf_idx, rr_rf_idx, rr_frf_idx, sg_rf_idx, sg_frf_idx;
  logic [4:0]    fx_fflags, rr_fflags, sg_fflags;

  e203_exu_wbck_arb #(.NCH(NCH), .XLEN(32), .FLEN(FL), .RFIDX_W(RW),
                      .RR_MODE(0), .DUAL_WB(1)) u_fix (
    .clk(clk), .rst_n(rst_n), .wbck_i(if_fix),
    .rf_wbck_o_ena(fx_rf_ena), .rf_wbck_o_wdat(fx_rf_wdat), .rf_wbck_o_rdidx(fx_rf_idx),
    .frf_wbck_o_ena(fx_frf_ena), .frf_wbck_o_wdat(fx_frf_wdat), .frf_wbck_o_rdidx(fx_frf_idx),
    .fflags_clr(fflags_clr), .fflags_o(fx_fflags));

  e203_exu_wbck_arb #(.NCH(NCH), .XLEN(32), .FLEN(FL), .RFIDX_W(RW),
                      .RR_MODE(1), .DUAL_WB(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .wbck_i(if_rr),
    .rf_wbck_o_ena(rr_rf_ena), .rf_wbck_o_wdat(rr_rf_wdat), .rf_wbck_o_rdidx(rr_rf_idx),
    .frf_wbck_o_ena(rr_frf_ena), .frf_wbck_o_wdat(rr_frf_wdat), .frf_wbck_o_rdidx(rr_frf_idx),
    .fflags_clr(fflags_clr), .fflags_o(rr_fflags));

  e203_exu_wbck_arb #(.NCH(NCH), .XLEN(32), .FLEN(FL), .RFIDX_W(RW),
                      .RR_MODE(0), .DUAL_WB(0)) u_sgl (
    .clk(clk), .rst_n(rst_n), .wbck_i(if_sgl),
    .rf_wbck_o_ena(sg_rf_ena), .rf_wbck_o_wdat(sg_rf_wdat), .rf_wbck_o_rdidx(sg_rf_idx),
    .frf_wbck_o_ena(sg_frf_ena), .frf_wbck_o_wdat(sg_frf_wdat), .frf_wbck_o_rdidx(sg_frf_idx),
    .fflags_clr(fflags_clr), .fflags_o(sg_fflags));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic v, input logic fpu,
                        input logic [31:0] wd, input logic [4:0] fl, input logic [4:0] idx);
    valid[c]          = v;
    rdfpu[c]          = fpu;
    wdat[c*FL +: FL]  = wd;
    flags[c*5 +: 5]   = fl;
    rdidx[c*RW +: RW] = idx;
  endtask

  // Advance one clock; land 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    fflags_clr = 1'b0;
    valid = '0; rdfpu = '0; wdat = '0; flags = '0; rdidx = '0;

    // Reset with every channel requesting an int write.
    set_ch(0, 1'b1, 1'b0, 32'h11, 5'b0, 5'd1);
    set_ch(1, 1'b1, 1'b0, 32'h22, 5'b0, 5'd2);
    set_ch(2, 1'b1, 1'b0, 32'h33, 5'b0, 5'd3);
    step(); step();
    check("rst_ready_fix", 32'(if_fix.ready), 32'h0);
    check("rst_ready_rr",  32'(if_rr.ready),  32'h0);
    check("rst_rf_ena",    32'(fx_rf_ena),    32'h0);
    check("rst_frf_ena",   32'(fx_frf_ena),   32'h0);
    check("rst_rf_wdat",   fx_rf_wdat,        32'h0);
    check("rst_fflags",    32'(fx_fflags),    32'h0);

    // Release: channel 0 wins everywhere in the first cycle.
    rst_n = 1'b1;
    #1;
    check("rel_ready_fix", 32'(if_fix.ready), 32'b001);
    check("rel_ready_rr",  32'(if_rr.ready),  32'b001);
    check("rel_ready_sgl", 32'(if_sgl.ready), 32'b001);
    step();
    check("rel_rf_ena",    32'(fx_rf_ena),    32'h1);
    check("rel_rf_wdat",   fx_rf_wdat,        32'h11);
    check("rel_rf_idx",    32'(fx_rf_idx),    32'd1);

    // Round-robin rotation 0,1,2,0 with data trailing one cycle.
    check("rr_ready_c1",   32'(if_rr.ready),  32'b010);
    check("rr_wdat_c1",    rr_rf_wdat,        32'h11);
    step();
    check("rr_ready_c2",   32'(if_rr.ready),  32'b100);
    check("rr_wdat_c2",    rr_rf_wdat,        32'h22);
    step();
    check("rr_ready_c3",   32'(if_rr.ready),  32'b001);
    check("rr_wdat_c3",    rr_rf_wdat,        32'h33);
    step();
    check("rr_ready_c4",   32'(if_rr.ready),  32'b010);
    check("rr_wdat_c4",    rr_rf_wdat,        32'h11);

    // Fixed priority: channels 1 and 2 only, channel 1 always wins.
    // Round-robin (ptr=1) alternates 1,2,1,2 and ends at ptr=0.
    valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("fix_ready_12", 32'(if_fix.ready), 32'b010);
      check("rr_ready_12",  32'(if_rr.ready),  (i % 2 == 0) ? 32'b010 : 32'b100);
      step();
      check("fix_wdat_12",  fx_rf_wdat,        32'h22);
    end

    // Round-robin wrap: grant ch1 to park ptr at 2, then ch0/ch1 request.
    valid = 3'b010;
    #1;
    check("wrap_ready_a",  32'(if_rr.ready),  32'b010);
    step();
    valid = 3'b011;
    #1;
    check("wrap_ready_b",  32'(if_rr.ready),  32'b001);
    step();
    check("wrap_ready_c",  32'(if_rr.ready),  32'b010);

    // Dual vs single grant: ch0 int rd5, ch1 FP rd7 in the same cycle.
    set_ch(0, 1'b1, 1'b0, 32'hA, 5'b0, 5'd5);
    set_ch(1, 1'b1, 1'b1, 32'hB, 5'b0, 5'd7);
    set_ch(2, 1'b0, 1'b0, 32'h0, 5'b0, 5'd0);
    #1;
    check("dual_ready",    32'(if_fix.ready), 32'b011);
    check("sgl_ready_a",   32'(if_sgl.ready), 32'b001);
    step();
    valid[0] = 1'b0;  // ch0 was accepted by every instance
    check("dual_rf_ena",   32'(fx_rf_ena),    32'h1);
    check("dual_rf_idx",   32'(fx_rf_idx),    32'd5);
    check("dual_rf_wdat",  fx_rf_wdat,        32'hA);
    check("dual_frf_ena",  32'(fx_frf_ena),   32'h1);
    check("dual_frf_idx",  32'(fx_frf_idx),   32'd7);
    check("dual_frf_wdat", fx_frf_wdat,       32'hB);
    check("sgl_rf_ena_a",  32'(sg_rf_ena),    32'h1);
    check("sgl_frf_ena_a", 32'(sg_frf_ena),   32'h0);
    #1;
    check("sgl_ready_b",   32'(if_sgl.ready), 32'b010);
    step();
    valid = '0;
    check("sgl_rf_ena_b",  32'(sg_rf_ena),    32'h0);
    check("sgl_frf_ena_b", 32'(sg_frf_ena),   32'h1);
    check("sgl_frf_idx_b", 32'(sg_frf_idx),   32'd7);
    step();
    check("idle_rf_ena",   32'(fx_rf_ena),    32'h0);
    check("idle_rf_hold",  fx_rf_wdat,        32'hA);
    check("idle_idx_hold", 32'(fx_rf_idx),    32'd5);

    // Sticky flags: FP NX, then int NV, then clear racing a new UF... OF.
    set_ch(1, 1'b1, 1'b1, 32'h1, 5'b00001, 5'd3);
    step();
    check("ff_after_fp",   32'(fx_fflags),    32'b00001);
    valid = '0;
    set_ch(0, 1'b1, 1'b0, 32'h2, 5'b10000, 5'd4);
    step();
    check("ff_after_int",  32'(fx_fflags),    32'b10001);
    valid = '0;
    set_ch(2, 1'b1, 1'b0, 32'h3, 5'b00100, 5'd6);
    fflags_clr = 1'b1;
    step();
    check("ff_clr_set",    32'(fx_fflags),    32'b00100);
    valid = '0;
    step();
    check("ff_clr_only",   32'(fx_fflags),    32'b00000);
    fflags_clr = 1'b0;

    // Asynchronous reset mid-operation with a request pending.
    set_ch(0, 1'b1, 1'b0, 32'h5, 5'b00010, 5'd9);
    step();
    check("pre_rst_ena",   32'(fx_rf_ena),    32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(if_fix.ready), 32'h0);
    check("mid_rst_ena",   32'(fx_rf_ena),    32'h0);
    check("mid_rst_wdat",  fx_rf_wdat,        32'h0);
    check("mid_rst_ff",    32'(fx_fflags),    32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
